// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame sequencer behind a UART byte receiver.
// It parses SYNC, LEN, PAYLOAD[LEN], CHK and buffers the payload.
// A frame is exposed to the host only after its checksum verifies.
// The checksum covers LEN plus the payload.
// Malformed, stalled or overrun traffic is dropped and flagged with a one-cycle pulse.
module uart_rx_frame_ctrl #(
    parameter int         CLOCK_RATE    = 100_000_000,
    parameter int         BAUD_RATE     = 9600,
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         TIMEOUT_BYTES = 4,
    localparam int        LW            = $clog2(MAX_LEN + 1),
    localparam int        AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          err_checksum,
    output logic          err_len,
    output logic          err_timeout,
    output logic          err_overrun
);

    // Inter-byte silence limit, measured in system clock cycles.
    localparam int TO_CYC = TIMEOUT_BYTES * 10 * (CLOCK_RATE / BAUD_RATE);
    localparam int TW     = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t        state;
    state_t        state_n;

    logic [7:0]    acc;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx;
    logic [TW-1:0] to_cnt;
    logic [7:0]    mem [MAX_LEN];

    logic          in_frame;
    logic          timed_out;
    logic          len_bad;
    logic          last_byte;
    logic [7:0]    chk_sum;

    logic          load_len;
    logic          take_byte;
    logic          err_checksum_n;
    logic          err_len_n;
    logic          err_timeout_n;
    logic          err_overrun_n;

    assign in_frame    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    // A byte that arrives on the expiry cycle takes priority over the timeout.
    assign timed_out   = in_frame && !rx_ready && (to_cnt == TW'(TO_CYC - 1));
    assign len_bad     = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
    assign last_byte   = (idx == len_q - LW'(1));
    assign chk_sum     = acc + rx_data;
    assign frame_valid = (state == S_HOLD);

    // Next-state and per-byte action decode.
    always_comb begin
        state_n        = state;
        load_len       = 1'b0;
        take_byte      = 1'b0;
        err_checksum_n = 1'b0;
        err_len_n      = 1'b0;
        err_timeout_n  = 1'b0;
        err_overrun_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (rx_ready && (rx_data == SYNC_BYTE)) begin
                    state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_ready) begin
                    if (len_bad) begin
                        err_len_n = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        load_len = 1'b1;
                        state_n  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_ready) begin
                    take_byte = 1'b1;
                    if (last_byte) begin
                        state_n = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_ready) begin
                    if (chk_sum == 8'd0) begin
                        state_n = S_HOLD;
                    end else begin
                        err_checksum_n = 1'b1;
                        state_n        = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    // A byte arriving together with the ack is treated as if the controller were already idle.
                    if (rx_ready && (rx_data == SYNC_BYTE)) begin
                        state_n = S_LEN;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (rx_ready) begin
                    err_overrun_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (timed_out) begin
            state_n       = S_IDLE;
            err_timeout_n = 1'b1;
        end
    end

    // State register and registered single-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            err_checksum <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            state        <= state_n;
            err_checksum <= err_checksum_n;
            err_len      <= err_len_n;
            err_timeout  <= err_timeout_n;
            err_overrun  <= err_overrun_n;
        end
    end

    // Frame bookkeeping: length, index, checksum accumulator, silence counter and held length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 8'd0;
            len_q     <= '0;
            idx       <= '0;
            to_cnt    <= '0;
            frame_len <= '0;
        end else begin
            if (rx_ready || !in_frame || timed_out) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (load_len) begin
                len_q <= rx_data[LW-1:0];
                acc   <= rx_data;
                idx   <= '0;
            end else if (take_byte) begin
                acc <= acc + rx_data;
                idx <= idx + LW'(1);
            end

            if (state_n == S_HOLD) begin
                if (state != S_HOLD) begin
                    frame_len <= len_q;
                end
            end else begin
                frame_len <= '0;
            end
        end
    end

    // Payload buffer write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (take_byte) begin
            mem[idx[AW-1:0]] <= rx_data;
        end
    end

    // Registered host read port, usable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'd0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a shortened timeout.
// The checksum byte is chosen so that (LEN + payload + CHK) mod 256 == 0.
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TO_CYC  = 2 * 10 * (100_000 / 10_000);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frame_ack = 1'b0;
    logic       err_checksum;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;

    int checks = 0;
    int failures = 0;
    int n_chk = 0;
    int n_len = 0;
    int n_to = 0;
    int n_ovr = 0;
    int base_chk;
    int base_len;
    int base_to;
    int base_ovr;

    uart_rx_frame_ctrl #(
        .CLOCK_RATE   (100_000),
        .BAUD_RATE    (10_000),
        .MAX_LEN      (MAX_LEN),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_BYTES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ack   (frame_ack),
        .err_checksum(err_checksum),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    // Running totals of error pulses, sampled mid-cycle.
    always @(negedge clk) begin
        n_chk <= n_chk + int'(err_checksum);
        n_len <= n_len + int'(err_len);
        n_to  <= n_to + int'(err_timeout);
        n_ovr <= n_ovr + int'(err_overrun);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One-cycle receiver strobe; returns at the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    task automatic ack_frame();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic snap();
        base_chk = n_chk;
        base_len = n_len;
        base_to  = n_to;
        base_ovr = n_ovr;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_valid", frame_valid, 0);
        check("rst_len", frame_len, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_errs", {err_checksum, err_len, err_timeout, err_overrun}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame
        snap();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("good_pre_valid", frame_valid, 0);
        send_byte(8'h97);
        check("good_valid", frame_valid, 1);
        check("good_len", frame_len, 3);
        read_check("good_rd0", 4'd0, 8'h11);
        read_check("good_rd1", 4'd1, 8'h22);
        read_check("good_rd2", 4'd2, 8'h33);
        ack_frame();
        check("good_ack_valid", frame_valid, 0);
        check("good_ack_len", frame_len, 0);
        check("good_no_err", (n_chk - base_chk) + (n_len - base_len) + (n_ovr - base_ovr), 0);

        // Bad checksum, then a single-byte frame
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h98);
        check("badchk_pulse", err_checksum, 1);
        check("badchk_valid", frame_valid, 0);
        @(negedge clk);
        check("badchk_pulse_end", err_checksum, 0);
        check("badchk_valid2", frame_valid, 0);
        // 01+7F+81 leaves 01 because the length byte is part of the sum
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h81);
        check("lenincl_pulse", err_checksum, 1);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h80);
        check("one_valid", frame_valid, 1);
        check("one_len", frame_len, 1);
        read_check("one_rd0", 4'd0, 8'h7F);
        ack_frame();

        // Length errors and idle noise
        snap();
        send_byte(8'hA5);
        send_byte(8'h00);
        check("len0_pulse", err_len, 1);
        @(negedge clk);
        check("len0_pulse_end", err_len, 0);
        send_byte(8'hA5);
        send_byte(8'h11);
        check("len17_pulse", err_len, 1);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        @(negedge clk);
        check("noise_len_cnt", n_len - base_len, 2);
        check("noise_other_cnt", (n_chk - base_chk) + (n_to - base_to) + (n_ovr - base_ovr), 0);
        // Max length accepted; SYNC inside the payload is plain data
        send_byte(8'hA5);
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            send_byte((i == 5) ? 8'hA5 : 8'(i));
        end
        // 10 + (0..15 with 5 replaced by A5) = 10 + 78 + A0 = 0x128 -> 28, CHK = D8
        send_byte(8'hD8);
        check("max_valid", frame_valid, 1);
        check("max_len", frame_len, 16);
        read_check("max_rd5", 4'd5, 8'hA5);
        read_check("max_rd15", 4'd15, 8'h0F);
        ack_frame();

        // Timeout
        snap();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (TO_CYC - 1) @(negedge clk);
        check("to_early", err_timeout, 0);
        @(negedge clk);
        check("to_pulse", err_timeout, 1);
        @(negedge clk);
        check("to_pulse_end", err_timeout, 0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'hFA);
        check("to_after_valid", frame_valid, 1);
        check("to_cnt", n_to - base_to, 1);

        // Overrun while holding, then ack colliding with SYNC
        snap();
        send_byte(8'h42);
        check("ovr_pulse", err_overrun, 1);
        check("ovr_valid", frame_valid, 1);
        check("ovr_len", frame_len, 1);
        read_check("ovr_rd0", 4'd0, 8'h05);
        check("ovr_pulse_end", err_overrun, 0);
        @(negedge clk);
        rx_data   = 8'hA5;
        rx_ready  = 1'b1;
        frame_ack = 1'b1;
        @(negedge clk);
        rx_ready  = 1'b0;
        frame_ack = 1'b0;
        check("coll_no_ovr", err_overrun, 0);
        check("coll_valid", frame_valid, 0);
        send_byte(8'h01);
        send_byte(8'h09);
        send_byte(8'hF6);
        check("coll_new_valid", frame_valid, 1);
        read_check("coll_rd0", 4'd0, 8'h09);
        check("coll_ovr_cnt", n_ovr - base_ovr, 1);
        ack_frame();

        // Reset mid-frame
        snap();
        rd_addr = 4'd0;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        @(negedge clk);
        check("mid_rd_before", rd_data, 8'h11);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_len", frame_len, 0);
        check("mid_rst_rd", rd_data, 0);
        check("mid_rst_errs", {err_checksum, err_len, err_timeout, err_overrun}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'hEF);
        check("mid_after_valid", frame_valid, 1);
        check("mid_after_len", frame_len, 1);
        check("mid_no_errs", (n_chk - base_chk) + (n_len - base_len) + (n_to - base_to) + (n_ovr - base_ovr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
